// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry {pc, inst} buffer.
// Generates sequential PCs, samples the combinational instruction memory, and
// presents the oldest buffered entry to ID over a valid/ready handshake.
//
// Handshake: id_valid is high whenever the queue holds at least one entry and
// does not depend on id_ready; an entry is consumed at a rising edge where
// id_valid & id_ready are both high. A redirect flushes the queue and restarts
// fetch at the word-aligned target; it overrides push and pop in that cycle.
module fetch_queue #(
   parameter int                     ADDR_LEN  = 32,
   parameter int                     INSTR_LEN = 32,
   parameter int                     DEPTH     = 4,
   parameter logic [ADDR_LEN-1:0]    RESET_PC  = '0,
   parameter int                     PC_STEP   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fetch_en,
   output logic [ADDR_LEN-1:0]       imem_addr,
   input  logic [INSTR_LEN-1:0]      imem_inst,
   input  logic                      redirect_valid,
   input  logic [ADDR_LEN-1:0]       redirect_pc,
   output logic                      id_valid,
   input  logic                      id_ready,
   output logic [ADDR_LEN-1:0]       id_pc,
   output logic [INSTR_LEN-1:0]      id_inst,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full
);

   localparam int                  PTR_W    = $clog2(DEPTH);
   localparam int                  CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
   localparam logic [ADDR_LEN-1:0] STEP     = ADDR_LEN'(PC_STEP);

   logic [ADDR_LEN-1:0]  pc_q   [DEPTH];
   logic [INSTR_LEN-1:0] inst_q [DEPTH];
   logic [ADDR_LEN-1:0]  fetch_pc;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     cnt;
   logic                 pop;
   logic                 push;
   logic [ADDR_LEN-1:0]  redirect_target;
   logic                 unused_low_bits;

   // Redirect targets are forced to a word boundary; the low bits are dropped.
   assign redirect_target = {redirect_pc[ADDR_LEN-1:2], 2'b00};
   assign unused_low_bits = ^redirect_pc[1:0];

   // A push while full is only allowed when the head leaves in the same cycle.
   assign pop  = id_valid & id_ready;
   assign push = fetch_en & ~redirect_valid & (~full | pop);

   assign imem_addr = fetch_pc;
   assign count     = cnt;
   assign full      = (cnt == FULL_CNT);
   assign id_valid  = (cnt != '0);

   // Head entry is gated to zero when the queue is empty.
   always_comb begin
      id_pc   = '0;
      id_inst = '0;
      if (id_valid) begin
         id_pc   = pc_q[rd_ptr];
         id_inst = inst_q[rd_ptr];
      end
   end

   // Fetch PC, pointers and occupancy; reset beats redirect beats push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_target;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            fetch_pc <= fetch_pc + STEP;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage; written only on an accepted push, never during reset.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pc_q[wr_ptr]   <= fetch_pc;
         inst_q[wr_ptr] <= imem_inst;
      end
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end. Replaces the fixed single-entry IF stage and IF/ID register of the 5-stage pipelined CPU.
- Generates sequential PCs and reads the combinational instruction memory. Buffers {pc, inst} pairs in a DEPTH-entry FIFO and presents them to ID with a valid/ready handshake.
- Supports redirect (branch/jump) flush and fetch enable.
- Sits between inst_memory and the ID stage; ID's stall maps to deasserting id_ready.

Parameters:
- ADDR_LEN, 32, PC/address width.
- INSTR_LEN, 32, instruction width.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  clock.
- rst  input  1  reset (see Behaviour).
- fetch_en  input  1  1 = fetch allowed this cycle; 0 = hold PC, no push.
- imem_addr  output  ADDR_LEN  address to inst_memory; equals fetch_pc.
- imem_inst  input  INSTR_LEN  instruction returned combinationally for imem_addr.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  ADDR_LEN  redirect target.
- id_valid  output  1  head entry valid.
- id_ready  input  1  ID accepts the head entry this cycle.
- id_pc  output  ADDR_LEN  PC of the head entry.
- id_inst  output  INSTR_LEN  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.

Behaviour:
- Reset: one clock (clk), synchronous active-high reset rst, sampled on the rising edge of clk. While rst is high at an edge:
  - fetch_pc <= RESET_PC.
  - rd_ptr, wr_ptr and count <= 0.
  - id_valid = 0, full = 0, count = 0.
  - id_pc and id_inst read 0 (storage contents are don't-care but outputs are gated to 0 when empty).
  - Reset mid-operation discards all entries identically, with no partial push.
- Handshake signals:
  - pop = id_valid & id_ready.
  - push = fetch_en & !redirect_valid & (!full | pop).
  - A push while full is legal only with a simultaneous pop; count then stays DEPTH.
- Push: write {fetch_pc, imem_inst} at wr_ptr; wr_ptr++ modulo DEPTH; fetch_pc <= fetch_pc + PC_STEP, truncated to ADDR_LEN (wraps at all-ones boundary).
- Pop: rd_ptr++ modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Outputs:
  - id_valid = (count != 0); id_pc and id_inst come from the entry at rd_ptr.
  - All outputs derive from registers; no combinational path from imem_inst or id_ready to id_*.
- Redirect (priority over push and pop):
  - At an edge with redirect_valid = 1: count, rd_ptr and wr_ptr <= 0; fetch_pc <= {redirect_pc[ADDR_LEN-1:2], 2'b00}.
  - A pop handshake in the same cycle still counts as accepted by ID; the squash of that instruction is the redirect source's responsibility.
  - Latency: redirect at edge t -> target pushed at edge t+1 -> id_valid=1 with id_pc=target after edge t+1.
  - Back-to-back redirects: the last one wins; no entries are pushed between them.
- Stall: id_ready = 0 holds the head stable (id_pc and id_inst unchanged). Fetch continues until full, then fetch_pc holds.
- fetch_en = 0: no push and fetch_pc holds. Pops and redirects still apply.
- Startup latency: the first edge after rst deasserts pushes RESET_PC; id_valid=1 after that edge.
- Throughput: with id_ready held at 1, one instruction per cycle and count settles at 1.

Test Plan:
- Reset, then id_ready=1 and fetch_en=1 for 6 cycles with memory returning inst=addr. Required: id_pc reads 0,4,8,12,16 on consecutive cycles; id_inst == id_pc; count == 1.
- id_ready=0 for 8 cycles, DEPTH=4. Required: count rises 1,2,3,4 then holds; full=1; imem_addr holds at 0x10; id_pc stays 0. Then id_ready=1 at full for 1 cycle: count stays 4, head becomes 4, imem_addr advances to 0x14.
- With count=3, assert redirect_valid for 1 cycle with redirect_pc=0x103 while id_ready=1. Required: next cycle count=0, id_valid=0, imem_addr=0x100. Cycle after: id_valid=1, id_pc=0x100.
- Redirects to 0x40 then 0x80 on consecutive cycles. Required: no entry with pc 0x40 ever appears; the first valid id_pc is 0x80.
- RESET_PC=32'hFFFF_FFF8, id_ready=1. Required: id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- With count=2, assert rst for 1 cycle. Required: next cycle id_valid=0, count=0, imem_addr=RESET_PC. fetch_en=0 afterwards: count stays 0 and imem_addr is constant.
